// File: rtl/tt_um_readback.sv
// tt_um_readback: streams selected weight-store columns out as LO/HI byte pairs
// over a valid/ready handshake, snapshotting each column before it is sent.
module tt_um_readback #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int WIDTH       = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         ena,
    input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0]      ui_weights,
    input  logic                                         ui_start,
    input  logic [$clog2(MAX_OUT_LEN*WIDTH)-1:0]         ui_first_col,
    input  logic [$clog2(MAX_OUT_LEN*WIDTH):0]           ui_num_cols,
    input  logic                                         ui_ready,
    output logic [7:0]                                   uo_data,
    output logic                                         uo_valid,
    output logic                                         uo_last,
    output logic                                         uo_busy,
    output logic                                         uo_done
);
    localparam int C    = MAX_OUT_LEN * WIDTH;
    localparam int CW   = $clog2(C);
    localparam int NW   = CW + 1;
    localparam int ROWS = (MAX_IN_LEN < 16) ? MAX_IN_LEN : 16;

    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d, col_nx, sel;
    logic [NW-1:0]   left_q, left_d;
    logic [15:0]     shadow_q, shadow_d, col_bits;
    logic            done_q, done_d, xfer;

    assign col_nx = (col_q == CW'(C - 1)) ? '0 : col_q + 1'b1;
    assign sel    = (state_q == IDLE) ? ui_first_col : col_nx;
    assign xfer   = ena & uo_valid & ui_ready;

    // Gather one column: row r of column c lives at bit r*C + c.
    always_comb begin
        col_bits = '0;
        for (int r = 0; r < ROWS; r++) col_bits[r] = ui_weights[r*C + int'(sel)];
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        left_d   = left_q;
        shadow_d = shadow_q;
        done_d   = ena ? 1'b0 : done_q;
        case (state_q)
            IDLE: if (ena && ui_start) begin
                state_d  = SEND_LO;
                col_d    = ui_first_col;
                left_d   = (ui_num_cols == '0) ? NW'(C) : ui_num_cols;
                shadow_d = col_bits;
            end
            SEND_LO: if (xfer) state_d = SEND_HI;
            SEND_HI: if (xfer) begin
                if (left_q == NW'(1)) begin
                    state_d = IDLE;
                    left_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d  = SEND_LO;
                    col_d    = col_nx;
                    left_d   = left_q - 1'b1;
                    shadow_d = col_bits;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            col_q    <= '0;
            left_q   <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            left_q   <= left_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
        end
    end

    assign uo_valid = state_q != IDLE;
    assign uo_busy  = state_q != IDLE;
    assign uo_data  = (state_q == SEND_LO) ? shadow_q[7:0] :
                      (state_q == SEND_HI) ? shadow_q[15:8] : 8'h00;
    assign uo_last  = (state_q == SEND_HI) && (left_q == NW'(1));
    assign uo_done  = done_q;
endmodule

// File: tb/tb_tt_um_readback.sv
// tb_tt_um_readback: randomized and directed readback scans checked by a
// byte scoreboard filled from a column-array model of the weight store.
module tb_tt_um_readback;
    localparam int C = 16;

    logic         clk = 1'b0, rst = 1'b1, ena = 1'b0;
    logic [255:0] ui_weights = '0;
    logic         ui_start = 1'b0, ui_ready = 1'b0;
    logic [3:0]   ui_first_col = '0;
    logic [4:0]   ui_num_cols = '0;
    logic [7:0]   uo_data;
    logic         uo_valid, uo_last, uo_busy, uo_done;

    tt_um_readback dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_weights(ui_weights),
        .ui_start(ui_start), .ui_first_col(ui_first_col), .ui_num_cols(ui_num_cols),
        .ui_ready(ui_ready), .uo_data(uo_data), .uo_valid(uo_valid),
        .uo_last(uo_last), .uo_busy(uo_busy), .uo_done(uo_done)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, beats = 0, dones = 0;
    logic [15:0] wmem [C];
    logic [8:0]  sbq [$];
    logic        exp_done = 1'b0, prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pack_weights();
        for (int c = 0; c < C; c++)
            for (int r = 0; r < 16; r++) ui_weights[r*C + c] = wmem[c][r];
    endtask

    task automatic push_scan(input int f, input int n);
        int nn;
        logic [15:0] v;
        nn = (n == 0) ? C : n;
        for (int i = 0; i < nn; i++) begin
            v = wmem[(f + i) % C];
            sbq.push_back({1'b0, v[7:0]});
            sbq.push_back({i == nn - 1, v[15:8]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input int f, input int n);
        push_scan(f, n);
        ui_first_col = 4'(f);
        ui_num_cols  = 5'(n);
        ui_start     = 1'b1;
        tick();
        ui_start = 1'b0;
        @(negedge clk);
        chk("start_latency_valid", uo_valid, 1);
    endtask

    task automatic drain(input bit rnd, output int bc);
        bit ok;
        ok = 1'b0;
        bc = 1;
        for (int k = 0; k < 800; k++) begin
            tick();
            ui_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            @(negedge clk);
            if (uo_busy) bc++;
            else if (sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("scan_completes", ok, 1);
        chk("scoreboard_empty", sbq.size(), 0);
    endtask

    // Monitor: a byte moves on the next rising edge whenever ena, valid and ready are all high here.
    initial forever begin
        logic [8:0] e;
        logic       x;
        @(negedge clk);
        if (rst) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("done_pulse", uo_done, exp_done);
            if (uo_done) dones++;
            if (!uo_busy) chk("idle_outputs", {uo_valid, uo_last, uo_data}, 0);
            if (prev_stall && uo_valid) chk("stall_hold", uo_data, prev_data);
            x = ena && uo_valid && ui_ready;
            exp_done = 1'b0;
            if (x) begin
                beats++;
                if (sbq.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_byte actual=%0h expected=none", {uo_last, uo_data});
                end else begin
                    e = sbq.pop_front();
                    chk("byte", {uo_last, uo_data}, e);
                    exp_done = e[8];
                end
            end
            prev_stall = uo_valid && !x;
            prev_data  = uo_data;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, b0, d0;
        for (int c = 0; c < C; c++) wmem[c] = 16'($urandom);
        pack_weights();
        ena = 1'b1;
        ui_start = 1'b1;
        tick(); tick();
        rst = 1'b0;
        ui_start = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {uo_data, uo_valid, uo_last, uo_busy, uo_done}, 0);

        // Start while disabled is ignored.
        ena = 1'b0; ui_start = 1'b1;
        tick(); tick();
        ui_start = 1'b0;
        @(negedge clk);
        chk("start_ignored_ena_low", uo_busy, 0);
        ena = 1'b1;

        // Single column A55A.
        wmem[5] = 16'hA55A; pack_weights();
        ui_ready = 1'b1;
        b0 = beats;
        start_scan(5, 1);
        drain(0, bc);
        chk("one_col_beats", beats - b0, 2);

        // Wrap 14 -> 15 -> 0.
        wmem[14] = 16'h0102; wmem[15] = 16'h0304; wmem[0] = 16'h0506; pack_weights();
        start_scan(14, 3);
        drain(0, bc);

        // Full scan with num=0.
        b0 = beats; d0 = dones;
        start_scan(0, 0);
        drain(0, bc);
        chk("full_scan_beats", beats - b0, 32);
        chk("full_scan_busy", bc, 32);
        chk("full_scan_dones", dones - d0, 1);

        // Stall in SEND_HI while weights change.
        wmem[7] = 16'h3CC3; pack_weights();
        start_scan(7, 1);
        tick();
        ui_ready = 1'b0;
        wmem[7] = 16'hFFFF; pack_weights();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hi_data", uo_data, 8'h3C);
            tick();
        end
        ui_ready = 1'b1;
        drain(0, bc);

        // Reset after the third beat of a 4-column scan.
        d0 = dones;
        start_scan(2, 4);
        tick(); tick(); tick();
        rst = 1'b1;
        sbq.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {uo_data, uo_valid, uo_last, uo_busy, uo_done}, 0);
        chk("abort_no_done", dones - d0, 0);
        b0 = beats;
        start_scan(0, 1);
        drain(0, bc);
        chk("after_abort_beats", beats - b0, 2);

        // Disable for two cycles mid-scan with a start pulse, then start while busy.
        b0 = beats;
        start_scan(3, 3);
        tick(); tick();
        ena = 1'b0; ui_start = 1'b1; ui_first_col = 4'd9; ui_num_cols = 5'd1;
        tick(); tick();
        ena = 1'b1;
        tick();
        ui_start = 1'b0;
        drain(0, bc);
        chk("ena_freeze_beats", beats - b0, 6);

        // Start accepted in the done cycle.
        start_scan(2, 1);
        tick(); tick();
        push_scan(4, 1);
        ui_first_col = 4'd4; ui_num_cols = 5'd1; ui_start = 1'b1;
        tick();
        ui_start = 1'b0;
        @(negedge clk);
        chk("restart_in_done_cycle", uo_valid, 1);
        drain(0, bc);

        // Randomized scans with random backpressure.
        for (int s = 0; s < 20; s++) begin
            for (int c = 0; c < C; c++) wmem[c] = 16'($urandom);
            pack_weights();
            ui_ready = 1'($urandom);
            start_scan($urandom_range(0, 15), $urandom_range(0, 16));
            drain(1, bc);
        end

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
